// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, FSM state
// encodings and instruction-class decode.
package cpu_defs_pkg;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

  // Execute-phase shape of an instruction
  typedef enum logic [2:0] {
    IC_THREE,   // rb op rc -> ra, ends in T5
    IC_UNARY,   // op rb -> ra, ends in T4
    IC_MULDIV,  // ra op rb -> LO/HI, ends in T6
    IC_MOVE,    // HI/LO -> ra, ends in T3
    IC_NONE     // nop, halt, unsupported: ends in T3
  } iclass_t;

  localparam logic [4:0] ALU_INC_DEFAULT = 5'd12;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  function automatic iclass_t op_class(input logic [4:0] op);
    iclass_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: c = IC_THREE;
      OP_NEG, OP_NOT:                  c = IC_UNARY;
      OP_MUL, OP_DIV:                  c = IC_MULDIV;
      OP_MFHI, OP_MFLO:                c = IC_MOVE;
      default:                         c = IC_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_field_decoder.sv
// 4-bit register field to 16-bit one-hot select; all zero when disabled.
module reg_field_decoder (
  input  logic [3:0]  field,
  input  logic        en,
  output logic [15:0] onehot
);

  // One bit per general register, at most one set
  always_comb begin
    onehot = '0;
    if (en) onehot[field] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch in T0-T2, execute in T3-T6, with a Moore
// decode of (state, IR) onto every Datapath strobe. The state register is
// the only storage; strobes are decoded from it and the live IR.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter logic [4:0] ALU_INC = ALU_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        Read,
  output logic [4:0]  OpCode,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        Run,
  output logic [3:0]  Present_state
);

  state_t      state, next_state;
  iclass_t     cls;
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic        terminal;
  logic        rin_en, rout_en;
  logic [3:0]  rout_sel;
  logic        unused_ir;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign cls       = op_class(op);
  assign unused_ir = ^IR[14:0];

  // Last execute cycle of the current instruction
  always_comb begin
    case (state)
      S_T3:    terminal = (cls == IC_MOVE) || (cls == IC_NONE);
      S_T4:    terminal = (cls == IC_UNARY);
      S_T5:    terminal = (cls == IC_THREE);
      S_T6:    terminal = 1'b1;
      default: terminal = 1'b0;
    endcase
  end

  // Next-state: linear walk through T-states, branch at the terminal cycle
  always_comb begin
    next_state = state;
    case (state)
      S_RST:    next_state = S_T0;
      S_T0:     next_state = S_T1;
      S_T1:     next_state = S_T2;
      S_T2:     next_state = S_T3;
      S_T3:     next_state = S_T4;
      S_T4:     next_state = S_T5;
      S_T5:     next_state = S_T6;
      S_T6:     next_state = S_T0;
      S_HALTED: next_state = S_HALTED;
      default:  next_state = S_RST;
    endcase
    if (terminal) begin
      if (Stop || (state == S_T3 && op == OP_HALT)) next_state = S_HALTED;
      else                                          next_state = S_T0;
    end
  end

  // State register; clr wins over everything
  always_ff @(posedge clk) begin
    if (clr) state <= S_RST;
    else     state <= next_state;
  end

  // Strobe decode from state and live IR
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0;   MARin = 1'b0;    Zin = 1'b0;
    PCin = 1'b0;  MDRin = 1'b0;   IRin = 1'b0;     Yin = 1'b0;
    HIin = 1'b0;  LOin = 1'b0;    Read = 1'b0;     OpCode = 5'd0;
    rin_en = 1'b0; rout_en = 1'b0; rout_sel = rb;
    Run = (state != S_RST) && (state != S_HALTED);
    case (state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; Zin = 1'b1; OpCode = ALU_INC; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls)
          IC_THREE:  begin rout_en = 1'b1; rout_sel = rb; Yin = 1'b1; end
          IC_UNARY:  begin rout_en = 1'b1; rout_sel = rb; Zin = 1'b1; OpCode = op; end
          IC_MULDIV: begin rout_en = 1'b1; rout_sel = ra; Yin = 1'b1; end
          IC_MOVE: begin
            rin_en = 1'b1;
            if (op == OP_MFHI) HIout = 1'b1;
            else               LOout = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          IC_THREE:  begin rout_en = 1'b1; rout_sel = rc; Zin = 1'b1; OpCode = op; end
          IC_UNARY:  begin Zlowout = 1'b1; rin_en = 1'b1; end
          IC_MULDIV: begin rout_en = 1'b1; rout_sel = rb; Zin = 1'b1; OpCode = op; end
          default: ;
        endcase
      end
      S_T5: begin
        if (cls == IC_THREE)  begin Zlowout = 1'b1; rin_en = 1'b1; end
        if (cls == IC_MULDIV) begin Zlowout = 1'b1; LOin = 1'b1; end
      end
      S_T6: begin
        if (cls == IC_MULDIV) begin Zhighout = 1'b1; HIin = 1'b1; end
      end
      default: ;
    endcase
  end

  assign Present_state = state;

  reg_field_decoder u_rin (
    .field  (ra),
    .en     (rin_en),
    .onehot (Rin)
  );

  reg_field_decoder u_rout (
    .field  (rout_sel),
    .en     (rout_en),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a cycle-by-cycle table of {inputs, expected
// outputs} is built up front, driven one row per clock, and checked through
// a scoreboard queue popped on the falling edge.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr, Stop;
  logic [31:0] IR;
  logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, Read, Run;
  logic [4:0]  OpCode;
  logic [15:0] Rin, Rout;
  logic [3:0]  Present_state;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .Stop(Stop),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
    .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .HIin(HIin), .LOin(LOin),
    .Read(Read), .OpCode(OpCode), .Rin(Rin), .Rout(Rout), .Run(Run),
    .Present_state(Present_state)
  );

  always #5 clk = ~clk;

  // Packed strobe bits
  localparam logic [15:0] C_PCOUT  = 16'h8000, C_ZLO   = 16'h4000,
                          C_ZHI    = 16'h2000, C_MDROUT = 16'h1000,
                          C_HIOUT  = 16'h0800, C_LOOUT = 16'h0400,
                          C_MARIN  = 16'h0200, C_ZIN   = 16'h0100,
                          C_PCIN   = 16'h0080, C_MDRIN = 16'h0040,
                          C_IRIN   = 16'h0020, C_YIN   = 16'h0010,
                          C_HIIN   = 16'h0008, C_LOIN  = 16'h0004,
                          C_READ   = 16'h0002, C_RUN   = 16'h0001;

  localparam logic [3:0] ST_RST = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3,
                         ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7,
                         ST_HLT = 4'd8;

  typedef struct {
    logic        clr;
    logic        stop;
    logic [31:0] ir;
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [4:0]  op;
    logic [15:0] rin;
    logic [15:0] rout;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   row_idx  = 0;

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  task automatic add_row(input logic c, input logic s, input logic [31:0] ir,
                         input logic [3:0] st, input logic [15:0] ctl,
                         input logic [4:0] op, input logic [15:0] rin,
                         input logic [15:0] rout);
    vec_t v;
    v.clr = c; v.stop = s; v.ir = ir; v.st = st; v.ctl = ctl;
    v.op = op; v.rin = rin; v.rout = rout;
    tbl.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] ir);
    add_row(0, 0, ir, ST_T0, C_PCOUT | C_MARIN | C_ZIN | C_RUN, 5'd12, 0, 0);
    add_row(0, 0, ir, ST_T1, C_ZLO | C_PCIN | C_READ | C_MDRIN | C_RUN, 0, 0, 0);
    add_row(0, 0, ir, ST_T2, C_MDROUT | C_IRIN | C_RUN, 0, 0, 0);
  endtask

  // Scoreboard check of every output on the falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      logic [15:0] ctl;
      e = sb.pop_front();
      ctl = {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, MARin, Zin,
             PCin, MDRin, IRin, Yin, HIin, LOin, Read, Run};
      n_checks++;
      if (Present_state === e.st && ctl === e.ctl && OpCode === e.op &&
          Rin === e.rin && Rout === e.rout)
        n_pass++;
      else
        $display("FAIL row%0d: got st=%0d ctl=%h op=%0d rin=%h rout=%h, want st=%0d ctl=%h op=%0d rin=%h rout=%h",
                 row_idx, Present_state, ctl, OpCode, Rin, Rout,
                 e.st, e.ctl, e.op, e.rin, e.rout);
      row_idx++;
    end
  end

  initial begin
    logic [31:0] i_and, i_not, i_mul, i_halt, i_nop;
    i_and  = 32'h28918000;
    i_not  = 32'h90080000;
    i_mul  = 32'h79A00000;
    i_halt = 32'hD8000000;
    i_nop  = mk_ir(5'b11010, 0, 0, 0);

    // reset, then and R1,R2,R3
    add_row(0, 0, 0, ST_RST, 0, 0, 0, 0);
    add_fetch(i_and);
    add_row(0, 0, i_and, ST_T3, C_YIN | C_RUN, 0, 0, 16'h0004);
    add_row(0, 0, i_and, ST_T4, C_ZIN | C_RUN, 5'd5, 0, 16'h0008);
    add_row(0, 0, i_and, ST_T5, C_ZLO | C_RUN, 0, 16'h0002, 0);
    // not R0,R1
    add_fetch(i_not);
    add_row(0, 0, i_not, ST_T3, C_ZIN | C_RUN, 5'd18, 0, 16'h0002);
    add_row(0, 0, i_not, ST_T4, C_ZLO | C_RUN, 0, 16'h0001, 0);
    // mul R3,R4; Stop at a non-terminal cycle is ignored
    add_fetch(i_mul);
    add_row(0, 1, i_mul, ST_T3, C_YIN | C_RUN, 0, 0, 16'h0008);
    add_row(0, 0, i_mul, ST_T4, C_ZIN | C_RUN, 5'd15, 0, 16'h0010);
    add_row(0, 0, i_mul, ST_T5, C_ZLO | C_LOIN | C_RUN, 0, 0, 0);
    add_row(0, 0, i_mul, ST_T6, C_ZHI | C_HIIN | C_RUN, 0, 0, 0);
    // mfhi R5, mflo R0
    add_fetch(mk_ir(5'b11000, 5, 0, 0));
    add_row(0, 0, mk_ir(5'b11000, 5, 0, 0), ST_T3, C_HIOUT | C_RUN, 0, 16'h0020, 0);
    add_fetch(mk_ir(5'b11001, 0, 0, 0));
    add_row(0, 0, mk_ir(5'b11001, 0, 0, 0), ST_T3, C_LOOUT | C_RUN, 0, 16'h0001, 0);
    // add R0,R15,R15 (aliased operands)
    add_fetch(mk_ir(5'b00011, 0, 15, 15));
    add_row(0, 0, mk_ir(5'b00011, 0, 15, 15), ST_T3, C_YIN | C_RUN, 0, 0, 16'h8000);
    add_row(0, 0, mk_ir(5'b00011, 0, 15, 15), ST_T4, C_ZIN | C_RUN, 5'd3, 0, 16'h8000);
    add_row(0, 0, mk_ir(5'b00011, 0, 15, 15), ST_T5, C_ZLO | C_RUN, 0, 16'h0001, 0);
    // shra R7,R9,R10
    add_fetch(mk_ir(5'b01010, 7, 9, 10));
    add_row(0, 0, mk_ir(5'b01010, 7, 9, 10), ST_T3, C_YIN | C_RUN, 0, 0, 16'h0200);
    add_row(0, 0, mk_ir(5'b01010, 7, 9, 10), ST_T4, C_ZIN | C_RUN, 5'd10, 0, 16'h0400);
    add_row(0, 0, mk_ir(5'b01010, 7, 9, 10), ST_T5, C_ZLO | C_RUN, 0, 16'h0080, 0);
    // nop, then an unsupported opcode
    add_fetch(i_nop);
    add_row(0, 0, i_nop, ST_T3, C_RUN, 0, 0, 0);
    add_fetch(mk_ir(5'b00000, 3, 4, 5));
    add_row(0, 0, mk_ir(5'b00000, 3, 4, 5), ST_T3, C_RUN, 0, 0, 0);
    // neg R2,R6 with Stop at its terminal T4
    add_fetch(mk_ir(5'b10001, 2, 6, 0));
    add_row(0, 0, mk_ir(5'b10001, 2, 6, 0), ST_T3, C_ZIN | C_RUN, 5'd17, 0, 16'h0040);
    add_row(0, 1, mk_ir(5'b10001, 2, 6, 0), ST_T4, C_ZLO | C_RUN, 0, 16'h0004, 0);
    add_row(0, 0, 0, ST_HLT, 0, 0, 0, 0);
    add_row(1, 0, 0, ST_HLT, 0, 0, 0, 0);
    add_row(0, 0, 0, ST_RST, 0, 0, 0, 0);
    // and with Stop at T5
    add_fetch(i_and);
    add_row(0, 0, i_and, ST_T3, C_YIN | C_RUN, 0, 0, 16'h0004);
    add_row(0, 0, i_and, ST_T4, C_ZIN | C_RUN, 5'd5, 0, 16'h0008);
    add_row(0, 1, i_and, ST_T5, C_ZLO | C_RUN, 0, 16'h0002, 0);
    add_row(0, 0, i_and, ST_HLT, 0, 0, 0, 0);
    add_row(1, 0, i_and, ST_HLT, 0, 0, 0, 0);
    add_row(0, 0, 0, ST_RST, 0, 0, 0, 0);
    // clr during mul T4: strobes shown that cycle, then abandoned
    add_fetch(i_mul);
    add_row(0, 0, i_mul, ST_T3, C_YIN | C_RUN, 0, 0, 16'h0008);
    add_row(1, 0, i_mul, ST_T4, C_ZIN | C_RUN, 5'd15, 0, 16'h0010);
    add_row(0, 0, i_mul, ST_RST, 0, 0, 0, 0);
    add_fetch(i_nop);
    add_row(0, 0, i_nop, ST_T3, C_RUN, 0, 0, 0);
    // halt, held 10 cycles, then clr back to fetch
    add_fetch(i_halt);
    add_row(0, 0, i_halt, ST_T3, C_RUN, 0, 0, 0);
    for (int k = 0; k < 10; k++) add_row(0, 0, i_halt, ST_HLT, 0, 0, 0, 0);
    add_row(1, 0, i_halt, ST_HLT, 0, 0, 0, 0);
    add_row(0, 0, i_halt, ST_RST, 0, 0, 0, 0);
    add_row(0, 0, i_halt, ST_T0, C_PCOUT | C_MARIN | C_ZIN | C_RUN, 5'd12, 0, 0);

    // clr held across the first edges
    clr = 1'b1; Stop = 1'b0; IR = '0;
    @(posedge clk);
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      clr  = tbl[i].clr;
      Stop = tbl[i].stop;
      IR   = tbl[i].ir;
      sb.push_back(tbl[i]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending rows, want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
